// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD test-pattern generator: panel size, RGB565 type,
// colour constants and the per-axis box stepping helpers (LCD_BOX_BOUNCE_EN selects the bounce helper).
package lcd_pkg;

  localparam int LCD_H_ACTIVE = 480;
  localparam int LCD_V_ACTIVE = 272;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t LCD_RGB_RED   = 16'hF800;
  localparam rgb565_t LCD_RGB_BLUE  = 16'h001F;
  localparam rgb565_t LCD_RGB_BLACK = 16'h0000;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    dir_e       dir;
    logic [9:0] pos;
  } axis_t;

  // Wrapping mode: jump back to 0 once a step would pass the limit.
  function automatic logic [9:0] wrap_step(input logic [9:0] pos, input logic [9:0] max,
                                           input logic [9:0] step);
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    return (sum > {1'b0, max}) ? 10'd0 : sum[9:0];
  endfunction

  // Bounce mode: land exactly on the edge and reverse in the same update.
  function automatic axis_t bounce_step(input dir_e dir, input logic [9:0] pos,
                                        input logic [9:0] max, input logic [9:0] step);
    axis_t       res;
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    res.dir = dir;
    res.pos = pos;
    if (dir == DIR_POS) begin
      if (sum >= {1'b0, max}) begin
        res.pos = max;
        res.dir = DIR_NEG;
      end else begin
        res.pos = sum[9:0];
      end
    end else begin
      if (pos <= step) begin
        res.pos = 10'd0;
        res.dir = DIR_POS;
      end else begin
        res.pos = pos - step;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lcd_box_mover.sv
// Box position state, advanced once per frame tick.
// LCD_BOX_BOUNCE_EN: bounce off the edges; otherwise wrap to 0 past the right/bottom limit.
module lcd_box_mover
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  output logic [9:0] o_box_x,
  output logic [9:0] o_box_y
);

  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0] STEP  = 10'(BOX_STEP);

  logic [9:0] r_box_x;
  logic [9:0] r_box_y;

`ifdef LCD_BOX_BOUNCE_EN
  dir_e  r_dir_x;
  dir_e  r_dir_y;
  axis_t w_next_x;
  axis_t w_next_y;

  always_comb begin
    w_next_x = bounce_step(r_dir_x, r_box_x, X_MAX, STEP);
    w_next_y = bounce_step(r_dir_y, r_box_y, Y_MAX, STEP);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_box_x <= '0;
      r_box_y <= '0;
      r_dir_x <= DIR_POS;
      r_dir_y <= DIR_POS;
    end else if (i_tick) begin
      r_box_x <= w_next_x.pos;
      r_box_y <= w_next_y.pos;
      r_dir_x <= w_next_x.dir;
      r_dir_y <= w_next_y.dir;
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_box_x <= '0;
      r_box_y <= '0;
    end else if (i_tick) begin
      r_box_x <= wrap_step(r_box_x, X_MAX, STEP);
      r_box_y <= wrap_step(r_box_y, Y_MAX, STEP);
    end
  end
`endif

  assign o_box_x = r_box_x;
  assign o_box_y = r_box_y;

endmodule

// File: rtl/lcd_pattern_gen.sv
// Moving-box test pattern for an RGB565 LCD, two-stage pipeline behind the timing generator.
// Define LCD_BOX_BOUNCE_EN for bouncing motion instead of wrap-around.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int      H_ACTIVE = LCD_H_ACTIVE,
  parameter int      V_ACTIVE = LCD_V_ACTIVE,
  parameter int      BOX_SIZE = 32,
  parameter int      BOX_STEP = 1,
  parameter rgb565_t BOX_RGB  = LCD_RGB_RED,
  parameter rgb565_t BG_RGB   = LCD_RGB_BLUE
) (
  input  logic       VGA_CLK,
  input  logic       RESETn,
  input  logic       HSYNC,
  input  logic       VSYNC,
  input  logic       DEN,
  input  logic [9:0] XPOS,
  input  logic [9:0] YPOS,
  output logic       LCD_HSYNC,
  output logic       LCD_VSYNC,
  output logic       LCD_DEN,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B
);

  logic       r_hs1, r_vs1, r_den1;
  logic [9:0] r_x1, r_y1, r_bx1, r_by1;
  logic       r_hs2, r_vs2, r_den2;
  rgb565_t    r_rgb2;

  logic        w_tick;
  logic [9:0]  w_box_x, w_box_y;
  logic [10:0] w_x_end, w_y_end;
  logic        w_inside;

  assign w_tick = r_vs1 & ~VSYNC;

  lcd_box_mover #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .BOX_SIZE(BOX_SIZE),
    .BOX_STEP(BOX_STEP)
  ) u_mover (
    .i_clk  (VGA_CLK),
    .i_rst_n(RESETn),
    .i_tick (w_tick),
    .o_box_x(w_box_x),
    .o_box_y(w_box_y)
  );

  // The box position is snapshotted with the pixel so a same-cycle tick cannot recolour it.
  always_ff @(posedge VGA_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b0;
      r_den1 <= 1'b0;
      r_x1   <= '0;
      r_y1   <= '0;
      r_bx1  <= '0;
      r_by1  <= '0;
    end else begin
      r_hs1  <= HSYNC;
      r_vs1  <= VSYNC;
      r_den1 <= DEN;
      r_x1   <= XPOS;
      r_y1   <= YPOS;
      r_bx1  <= w_box_x;
      r_by1  <= w_box_y;
    end
  end

  assign w_x_end  = {1'b0, r_bx1} + 11'(BOX_SIZE);
  assign w_y_end  = {1'b0, r_by1} + 11'(BOX_SIZE);
  assign w_inside = ({1'b0, r_x1} >= {1'b0, r_bx1}) && ({1'b0, r_x1} < w_x_end) &&
                    ({1'b0, r_y1} >= {1'b0, r_by1}) && ({1'b0, r_y1} < w_y_end);

  always_ff @(posedge VGA_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_den2 <= 1'b0;
      r_rgb2 <= LCD_RGB_BLACK;
    end else begin
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_den2 <= r_den1;
      r_rgb2 <= !r_den1 ? LCD_RGB_BLACK : (w_inside ? BOX_RGB : BG_RGB);
    end
  end

  assign LCD_HSYNC = r_hs2;
  assign LCD_VSYNC = r_vs2;
  assign LCD_DEN   = r_den2;
  assign LCD_R     = r_rgb2.r;
  assign LCD_G     = r_rgb2.g;
  assign LCD_B     = r_rgb2.b;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed self-checking bench for lcd_pattern_gen; expectations follow LCD_BOX_BOUNCE_EN when defined.
module tb_lcd_pattern_gen;
  import lcd_pkg::*;

  logic       VGA_CLK, RESETn, HSYNC, VSYNC, DEN;
  logic [9:0] XPOS, YPOS;
  logic       LCD_HSYNC, LCD_VSYNC, LCD_DEN;
  logic [4:0] LCD_R, LCD_B;
  logic [5:0] LCD_G;

  int checks = 0;
  int errors = 0;

`ifdef LCD_BOX_BOUNCE_EN
  localparam logic [9:0] Y_AT_241 = 10'd239;
  localparam logic [9:0] Y_AT_448 = 10'd32;
  localparam logic [9:0] X_AT_449 = 10'd447;
  localparam logic [9:0] Y_AT_449 = 10'd31;
`else
  localparam logic [9:0] Y_AT_241 = 10'd0;
  localparam logic [9:0] Y_AT_448 = 10'd207;
  localparam logic [9:0] X_AT_449 = 10'd0;
  localparam logic [9:0] Y_AT_449 = 10'd208;
`endif

  lcd_pattern_gen u_dut (
    .VGA_CLK  (VGA_CLK),
    .RESETn   (RESETn),
    .HSYNC    (HSYNC),
    .VSYNC    (VSYNC),
    .DEN      (DEN),
    .XPOS     (XPOS),
    .YPOS     (YPOS),
    .LCD_HSYNC(LCD_HSYNC),
    .LCD_VSYNC(LCD_VSYNC),
    .LCD_DEN  (LCD_DEN),
    .LCD_R    (LCD_R),
    .LCD_G    (LCD_G),
    .LCD_B    (LCD_B)
  );

  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  task automatic step();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic frame_tick();
    VSYNC = 1'b1;
    step();
    VSYNC = 1'b0;
    step();
  endtask

  task automatic drive_pixel(input logic [9:0] x, input logic [9:0] y, output logic [15:0] rgb);
    DEN = 1'b1; XPOS = x; YPOS = y;
    step();
    DEN = 1'b0;
    step();
    rgb = {LCD_R, LCD_G, LCD_B};
  endtask

  task automatic test_reset();
    RESETn = 1'b0; HSYNC = 1'b1; VSYNC = 1'b0; DEN = 1'b0; XPOS = '0; YPOS = '0;
    step(); step(); step();
    checks++;
    if ({LCD_HSYNC, LCD_VSYNC, LCD_DEN} !== 3'b110) begin
      errors++; $display("FAIL reset_sync: got %b want 110", {LCD_HSYNC, LCD_VSYNC, LCD_DEN});
    end
    checks++;
    if ({LCD_R, LCD_G, LCD_B} !== 16'h0000) begin
      errors++; $display("FAIL reset_rgb: got %h want 0000", {LCD_R, LCD_G, LCD_B});
    end
    RESETn = 1'b1;
    step();
    checks++;
    if ({u_dut.w_box_x, u_dut.w_box_y} !== 20'd0) begin
      errors++; $display("FAIL reset_no_tick: box got (%0d,%0d) want (0,0)", u_dut.w_box_x, u_dut.w_box_y);
    end
    step();
    checks++;
    if (LCD_DEN !== 1'b0 || {LCD_R, LCD_G, LCD_B} !== 16'h0000 || u_dut.w_box_x !== 10'd0) begin
      errors++; $display("FAIL reset_idle: den=%b rgb=%h bx=%0d want den=0 rgb=0000 bx=0",
                         LCD_DEN, {LCD_R, LCD_G, LCD_B}, u_dut.w_box_x);
    end
  endtask

  task automatic test_sync_delay();
    HSYNC = 1'b0;
    step();
    checks++;
    if (LCD_HSYNC !== 1'b1) begin
      errors++; $display("FAIL hsync_lat1: got %b want 1", LCD_HSYNC);
    end
    step();
    checks++;
    if (LCD_HSYNC !== 1'b0) begin
      errors++; $display("FAIL hsync_lat2: got %b want 0", LCD_HSYNC);
    end
    HSYNC = 1'b1;
    step(); step();
  endtask

  task automatic test_pixel();
    logic [15:0] rgb;
    DEN = 1'b1; XPOS = 10'd0; YPOS = 10'd0;
    step();
    DEN = 1'b0;
    checks++;
    if (LCD_DEN !== 1'b0) begin
      errors++; $display("FAIL den_lat1: got %b want 0", LCD_DEN);
    end
    step();
    checks++;
    if (LCD_DEN !== 1'b1 || {LCD_R, LCD_G, LCD_B} !== 16'hF800) begin
      errors++; $display("FAIL pix_0_0: den=%b rgb=%h want den=1 rgb=f800", LCD_DEN, {LCD_R, LCD_G, LCD_B});
    end
    drive_pixel(10'd32, 10'd0, rgb);
    checks++;
    if (rgb !== 16'h001F) begin
      errors++; $display("FAIL pix_32_0: got %h want 001f", rgb);
    end
    drive_pixel(10'd31, 10'd31, rgb);
    checks++;
    if (rgb !== 16'hF800) begin
      errors++; $display("FAIL pix_31_31: got %h want f800", rgb);
    end
    drive_pixel(10'd0, 10'd32, rgb);
    checks++;
    if (rgb !== 16'h001F) begin
      errors++; $display("FAIL pix_0_32: got %h want 001f", rgb);
    end
    XPOS = 10'd0; YPOS = 10'd0; DEN = 1'b0;
    step(); step();
    checks++;
    if (LCD_DEN !== 1'b0 || {LCD_R, LCD_G, LCD_B} !== 16'h0000) begin
      errors++; $display("FAIL pix_den0: den=%b rgb=%h want den=0 rgb=0000", LCD_DEN, {LCD_R, LCD_G, LCD_B});
    end
  endtask

  task automatic test_move();
    logic [15:0] rgb;
    for (int i = 0; i < 3; i++) frame_tick();
    checks++;
    if (u_dut.w_box_x !== 10'd3 || u_dut.w_box_y !== 10'd3) begin
      errors++; $display("FAIL move3: box got (%0d,%0d) want (3,3)", u_dut.w_box_x, u_dut.w_box_y);
    end
    drive_pixel(10'd34, 10'd34, rgb);
    checks++;
    if (rgb !== 16'hF800) begin
      errors++; $display("FAIL pix_34_34: got %h want f800", rgb);
    end
    drive_pixel(10'd35, 10'd2, rgb);
    checks++;
    if (rgb !== 16'h001F) begin
      errors++; $display("FAIL pix_35_2: got %h want 001f", rgb);
    end
    drive_pixel(10'd2, 10'd3, rgb);
    checks++;
    if (rgb !== 16'h001F) begin
      errors++; $display("FAIL pix_2_3: got %h want 001f", rgb);
    end
  endtask

  task automatic test_tick_coincident();
    VSYNC = 1'b1;
    step();
    VSYNC = 1'b0; DEN = 1'b1; XPOS = 10'd3; YPOS = 10'd3;
    step();
    DEN = 1'b0;
    step();
    checks++;
    if ({LCD_R, LCD_G, LCD_B} !== 16'hF800) begin
      errors++; $display("FAIL tick_pre_update: got %h want f800", {LCD_R, LCD_G, LCD_B});
    end
    checks++;
    if (u_dut.w_box_x !== 10'd4 || u_dut.w_box_y !== 10'd4) begin
      errors++; $display("FAIL tick_update: box got (%0d,%0d) want (4,4)", u_dut.w_box_x, u_dut.w_box_y);
    end
  endtask

  task automatic test_edges();
    logic [15:0] rgb;
    RESETn = 1'b0;
    step();
    RESETn = 1'b1;
    for (int i = 1; i <= 448; i++) begin
      frame_tick();
      if (i == 240) begin
        checks++;
        if (u_dut.w_box_y !== 10'd240) begin
          errors++; $display("FAIL y_at_240: got %0d want 240", u_dut.w_box_y);
        end
`ifdef LCD_BOX_BOUNCE_EN
        checks++;
        if (u_dut.u_mover.r_dir_y !== DIR_NEG) begin
          errors++; $display("FAIL ydir_at_240: got %b want 1", u_dut.u_mover.r_dir_y);
        end
`endif
      end
      if (i == 241) begin
        checks++;
        if (u_dut.w_box_y !== Y_AT_241) begin
          errors++; $display("FAIL y_at_241: got %0d want %0d", u_dut.w_box_y, Y_AT_241);
        end
      end
    end
    checks++;
    if (u_dut.w_box_x !== 10'd448 || u_dut.w_box_y !== Y_AT_448) begin
      errors++; $display("FAIL box_448: got (%0d,%0d) want (448,%0d)", u_dut.w_box_x, u_dut.w_box_y, Y_AT_448);
    end
    drive_pixel(10'd479, Y_AT_448, rgb);
    checks++;
    if (rgb !== 16'hF800) begin
      errors++; $display("FAIL pix_479: got %h want f800", rgb);
    end
    drive_pixel(10'd480, Y_AT_448, rgb);
    checks++;
    if (rgb !== 16'h001F) begin
      errors++; $display("FAIL pix_480: got %h want 001f", rgb);
    end
    drive_pixel(10'd1023, 10'd1023, rgb);
    checks++;
    if (rgb !== 16'h001F) begin
      errors++; $display("FAIL pix_1023: got %h want 001f", rgb);
    end
    frame_tick();
    checks++;
    if (u_dut.w_box_x !== X_AT_449 || u_dut.w_box_y !== Y_AT_449) begin
      errors++; $display("FAIL box_449: got (%0d,%0d) want (%0d,%0d)",
                         u_dut.w_box_x, u_dut.w_box_y, X_AT_449, Y_AT_449);
    end
`ifdef LCD_BOX_BOUNCE_EN
    checks++;
    if (u_dut.u_mover.r_dir_x !== DIR_NEG) begin
      errors++; $display("FAIL xdir_449: got %b want 1", u_dut.u_mover.r_dir_x);
    end
`endif
  endtask

  task automatic test_reset_mid();
    DEN = 1'b1; XPOS = 10'd0; YPOS = 10'd0;
    step(); step();
    checks++;
    if (LCD_DEN !== 1'b1 || {LCD_R, LCD_G, LCD_B} === 16'h0000) begin
      errors++; $display("FAIL pre_reset_active: den=%b rgb=%h want den=1 rgb nonzero",
                         LCD_DEN, {LCD_R, LCD_G, LCD_B});
    end
    #2;
    RESETn = 1'b0;
    #1;
    checks++;
    if (LCD_DEN !== 1'b0 || {LCD_R, LCD_G, LCD_B} !== 16'h0000 || LCD_HSYNC !== 1'b1) begin
      errors++; $display("FAIL mid_reset_out: den=%b rgb=%h hs=%b want den=0 rgb=0000 hs=1",
                         LCD_DEN, {LCD_R, LCD_G, LCD_B}, LCD_HSYNC);
    end
    checks++;
    if (u_dut.w_box_x !== 10'd0 || u_dut.w_box_y !== 10'd0) begin
      errors++; $display("FAIL mid_reset_box: got (%0d,%0d) want (0,0)", u_dut.w_box_x, u_dut.w_box_y);
    end
    step();
    RESETn = 1'b1; DEN = 1'b0; VSYNC = 1'b0;
    step();
    frame_tick();
    checks++;
    if (u_dut.w_box_x !== 10'd1 || u_dut.w_box_y !== 10'd1) begin
      errors++; $display("FAIL resume_tick: got (%0d,%0d) want (1,1)", u_dut.w_box_x, u_dut.w_box_y);
    end
  endtask

  initial begin
    test_reset();
    test_sync_delay();
    test_pixel();
    test_move();
    test_tick_coincident();
    test_edges();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_pattern_gen.md
LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 272, visible lines per frame.
REQ-003 SHALL have parameter BOX_SIZE, default 32, box edge length in pixels.
REQ-004 SHALL have parameter BOX_STEP, default 1, pixels moved per frame on each axis.
REQ-005 SHALL have parameters BOX_RGB, default 16'hF800, and BG_RGB, default 16'h001F, as RGB565 colours.
REQ-006 SHALL have port VGA_CLK, input, 1 bit, pixel clock; only clock in the block.
REQ-007 SHALL have port RESETn, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have ports HSYNC, VSYNC, DEN, input, 1 bit each; timing from the LCD driver; syncs active low.
REQ-009 SHALL have ports XPOS and YPOS, input, 10 bits each; current pixel coordinate, valid when DEN=1.
REQ-010 SHALL have ports LCD_HSYNC, LCD_VSYNC, LCD_DEN, output, 1 bit each; delayed copies of the timing inputs.
REQ-011 SHALL have ports LCD_R (5 bits), LCD_G (6 bits) and LCD_B (5 bits), outputs; pixel colour.

Function
REQ-012 SHALL register HSYNC, VSYNC, DEN, XPOS and YPOS in stage 1 and register colour plus delayed timing in stage 2, for a fixed latency of 2 VGA_CLK cycles on all outputs.
REQ-013 SHALL detect a frame tick when the registered VSYNC is 1 and the input VSYNC is 0 (falling edge).
REQ-014 SHALL update box_x/box_y (10 bits each) in the cycle after a frame tick, and at no other time.
REQ-015 SHALL keep box_x within 0..H_ACTIVE-BOX_SIZE and box_y within 0..V_ACTIVE-BOX_SIZE at all times.
REQ-016 SHALL mark a pixel as inside the box when XPOS>=box_x, XPOS<box_x+BOX_SIZE, YPOS>=box_y and YPOS<box_y+BOX_SIZE; sums SHALL be computed at 11 bits so they cannot overflow.
REQ-017 SHALL output BOX_RGB for inside pixels and BG_RGB for outside pixels when the stage-1 DEN is 1, and all-zero RGB when it is 0.
REQ-018 SHALL colour each pixel using the box position held at the time of its stage-1 sample; a tick coincident with DEN=1 SHALL use the pre-update position.
REQ-019 SHALL pass XPOS/YPOS values at or beyond H_ACTIVE/V_ACTIVE through the comparison unchanged, with no wrap.

Reset
REQ-020 SHALL, while RESETn=0, force LCD_HSYNC=1, LCD_VSYNC=1, LCD_DEN=0, LCD_R/G/B=0, box_x=box_y=0, both directions positive, and registered VSYNC=0.
REQ-021 SHALL, because registered VSYNC resets to 0, produce no frame tick in the first cycle after reset release, even when VSYNC is low.
REQ-022 SHALL, on reset asserted mid-frame, clear state immediately and resume on the next observed VSYNC falling edge.

Configuration
REQ-023 SHALL, with macro LCD_BOX_BOUNCE_EN defined, move each axis by +/-BOX_STEP, clamp to the limit when the next step would exceed 0 or the maximum, and invert that axis direction in the same update.
REQ-024 SHALL, without LCD_BOX_BOUNCE_EN, always move +BOX_STEP and set an axis to 0 when the next step would exceed its maximum; direction registers SHALL be absent.

Structure
REQ-025 SHALL take H_ACTIVE/V_ACTIVE defaults, the rgb565 typedef and the colour constants from shared package lcd_pkg.
REQ-026 SHALL implement the box position/direction state in one sub-module, lcd_box_mover (inputs: clock, reset, tick; outputs: box_x, box_y).

Verification
REQ-027 SHALL verify: reset released with VSYNC low -> no tick; box_x=box_y=0; outputs LCD_DEN=0, RGB=0.
REQ-028 SHALL verify: DEN=1, XPOS=0, YPOS=0 after reset -> 2 cycles later R=31, G=0, B=0; XPOS=32 -> R=0, G=0, B=31.
REQ-029 SHALL verify: 3 VSYNC falling edges -> box_x=box_y=3; pixel (34,34) is box colour and (35,2) is background.
REQ-030 SHALL verify: with bounce, 448 ticks -> box_x=448; next tick -> 447 with x direction negative; box_y reverses at 240.
REQ-031 SHALL verify: without bounce, box_x=448 then one tick -> box_x=0.
REQ-032 SHALL verify: RESETn pulsed low mid-line with DEN=1 -> outputs zero within the same cycle and box returns to (0,0).
